// File: rtl/ddr_wr_packer_pkg.sv
// ----------------------------------------------------------------------------
// ddr_wr_packer_pkg
// Shared definitions for the acquisition write packer and the DDR write/read
// FSM that drains the 256-bit FIFO behind it.
//   - DDR_DATA_W     : width of one acquisition sample
//   - DDR_PACK_NUM   : samples packed into one FIFO word
//   - DDR_SETTLE_CYC : quiet cycles between the last FIFO write and complete
//   - DDR_WORD_W     : FIFO / DDR burst word width
//   - pack_state_e   : packer FSM state encoding (3-bit)
// ----------------------------------------------------------------------------
package ddr_wr_packer_pkg;

    localparam int DDR_DATA_W     = 32;
    localparam int DDR_PACK_NUM   = 8;
    localparam int DDR_SETTLE_CYC = 4;
    localparam int DDR_WORD_W     = DDR_DATA_W * DDR_PACK_NUM;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_FLUSH  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_DONE   = 3'd4
    } pack_state_e;

endpackage

// File: rtl/ddr_wr_packer.sv
// ----------------------------------------------------------------------------
// ddr_wr_packer
// Packs PACK_NUM consecutive DATA_WIDTH-bit acquisition samples into one wide
// word and writes it into the FIFO that feeds the DDR write/read FSM. On stop
// the partial word is flushed with unfilled lanes zeroed; after SETTLE_CYC
// quiet cycles o_complete is raised for the DDR FSM.
//
// Ports
//   ddr_ui_clk     in   sole clock, rising edge
//   ddr_log_rst_n  in   synchronous reset, active-low
//   i_acq_start    in   pulse: begin acquisition (honoured in IDLE/DONE)
//   i_acq_stop     in   pulse: end acquisition and flush (honoured in RUN)
//   i_data_vld     in   sample qualifier (honoured in RUN)
//   iv_data        in   sample
//   i_fifo_full    in   FIFO write-side full
//   o_fifo_wr_en   out  registered FIFO write strobe
//   ov_fifo_din    out  packed word, valid with o_fifo_wr_en
//   o_complete     out  level, high from DONE entry until the next start
//   o_overflow     out  sticky: a full packed word was dropped
//   ov_word_cnt    out  FIFO words written since the last start
//
// Because the write strobe is registered, i_fifo_full is evaluated in the
// cycle the write is committed, i.e. the cycle before o_fifo_wr_en is high.
// ----------------------------------------------------------------------------
module ddr_wr_packer
    import ddr_wr_packer_pkg::*;
#(
    parameter int DATA_WIDTH = DDR_DATA_W,
    parameter int PACK_NUM   = DDR_PACK_NUM,
    parameter int SETTLE_CYC = DDR_SETTLE_CYC
) (
    input  logic                             ddr_ui_clk,
    input  logic                             ddr_log_rst_n,
    input  logic                             i_acq_start,
    input  logic                             i_acq_stop,
    input  logic                             i_data_vld,
    input  logic [DATA_WIDTH-1:0]            iv_data,
    input  logic                             i_fifo_full,
    output logic                             o_fifo_wr_en,
    output logic [DATA_WIDTH*PACK_NUM-1:0]   ov_fifo_din,
    output logic                             o_complete,
    output logic                             o_overflow,
    output logic [31:0]                      ov_word_cnt
);

    localparam int WORD_W   = DATA_WIDTH * PACK_NUM;
    localparam int LANE_W   = (PACK_NUM > 1) ? $clog2(PACK_NUM) : 1;
    localparam int SETTLE_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [LANE_W-1:0]   LANE_ZERO   = LANE_W'(0);
    localparam logic [LANE_W-1:0]   LANE_ONE    = LANE_W'(1);
    localparam logic [LANE_W-1:0]   LANE_LAST   = LANE_W'(PACK_NUM - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_ZERO = SETTLE_W'(0);
    localparam logic [SETTLE_W-1:0] SETTLE_ONE  = SETTLE_W'(1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);
    localparam logic [WORD_W-1:0]   WORD_ZERO   = WORD_W'(0);

    pack_state_e          state_r;
    pack_state_e          state_nxt_s;

    logic [LANE_W-1:0]    lane_cnt_r;
    logic [WORD_W-1:0]    pack_r;
    logic [SETTLE_W-1:0]  settle_cnt_r;

    logic                 wr_en_r;
    logic [WORD_W-1:0]    din_r;
    logic                 complete_r;
    logic                 overflow_r;
    logic [31:0]          word_cnt_r;

    logic                 start_s;
    logic                 accept_s;
    logic                 lane_last_s;
    logic                 flush_wr_s;
    logic                 settle_end_s;
    logic                 wr_commit_s;
    logic                 drop_s;
    logic [31:0]          lane_base_s;
    logic [WORD_W-1:0]    pack_nxt_s;
    logic [WORD_W-1:0]    wr_word_s;

    // State register
    always_ff @(posedge ddr_ui_clk) begin
        if (!ddr_log_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode and per-cycle control strobes
    always_comb begin
        start_s      = 1'b0;
        accept_s     = 1'b0;
        lane_last_s  = 1'b0;
        flush_wr_s   = 1'b0;
        settle_end_s = 1'b0;
        state_nxt_s  = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (i_acq_start) begin
                    start_s     = 1'b1;
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_RUN: begin
                // A sample arriving with stop is still packed before flushing
                accept_s    = i_data_vld;
                lane_last_s = i_data_vld & (lane_cnt_r == LANE_LAST);
                if (i_acq_stop) begin
                    state_nxt_s = ST_FLUSH;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                // Lane count returns to zero once the padded word is committed,
                // so the cycle carrying that write is still spent in FLUSH
                if (lane_cnt_r == LANE_ZERO) begin
                    state_nxt_s = ST_SETTLE;
                end else begin
                    flush_wr_s  = ~i_fifo_full;
                    state_nxt_s = ST_FLUSH;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_r == SETTLE_LAST) begin
                    settle_end_s = 1'b1;
                    state_nxt_s  = ST_DONE;
                end else begin
                    state_nxt_s  = ST_SETTLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Merge the accepted sample into its lane; lane k sits at bits [k*W +: W]
    always_comb begin
        lane_base_s = 32'(lane_cnt_r) * 32'(DATA_WIDTH);
        pack_nxt_s  = pack_r;
        if (accept_s) begin
            pack_nxt_s[lane_base_s +: DATA_WIDTH] = iv_data;
        end else begin
            pack_nxt_s = pack_r;
        end
    end

    // Select the word to commit and whether a completed word is dropped
    always_comb begin
        wr_commit_s = (lane_last_s & ~i_fifo_full) | flush_wr_s;
        drop_s      = lane_last_s & i_fifo_full;
        if (flush_wr_s) begin
            wr_word_s = pack_r;
        end else begin
            wr_word_s = pack_nxt_s;
        end
    end

    // Lane counter and partial-word register
    always_ff @(posedge ddr_ui_clk) begin
        if (!ddr_log_rst_n) begin
            lane_cnt_r <= LANE_ZERO;
            pack_r     <= WORD_ZERO;
        end else if (start_s || lane_last_s || flush_wr_s) begin
            lane_cnt_r <= LANE_ZERO;
            pack_r     <= WORD_ZERO;
        end else if (accept_s) begin
            lane_cnt_r <= lane_cnt_r + LANE_ONE;
            pack_r     <= pack_nxt_s;
        end else begin
            lane_cnt_r <= lane_cnt_r;
            pack_r     <= pack_r;
        end
    end

    // Settle counter, held at zero outside SETTLE so each entry starts fresh
    always_ff @(posedge ddr_ui_clk) begin
        if (!ddr_log_rst_n) begin
            settle_cnt_r <= SETTLE_ZERO;
        end else if ((state_r == ST_SETTLE) && !settle_end_s) begin
            settle_cnt_r <= settle_cnt_r + SETTLE_ONE;
        end else begin
            settle_cnt_r <= SETTLE_ZERO;
        end
    end

    // Registered FIFO write strobe and data
    always_ff @(posedge ddr_ui_clk) begin
        if (!ddr_log_rst_n) begin
            wr_en_r <= 1'b0;
            din_r   <= WORD_ZERO;
        end else if (wr_commit_s) begin
            wr_en_r <= 1'b1;
            din_r   <= wr_word_s;
        end else begin
            wr_en_r <= 1'b0;
            din_r   <= din_r;
        end
    end

    // Sticky overflow, completion level and written-word counter
    always_ff @(posedge ddr_ui_clk) begin
        if (!ddr_log_rst_n) begin
            overflow_r <= 1'b0;
            complete_r <= 1'b0;
            word_cnt_r <= 32'd0;
        end else if (start_s) begin
            overflow_r <= 1'b0;
            complete_r <= 1'b0;
            word_cnt_r <= 32'd0;
        end else begin
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
            if (settle_end_s) begin
                complete_r <= 1'b1;
            end else begin
                complete_r <= complete_r;
            end
            if (wr_commit_s) begin
                word_cnt_r <= word_cnt_r + 32'd1;
            end else begin
                word_cnt_r <= word_cnt_r;
            end
        end
    end

    assign o_fifo_wr_en = wr_en_r;
    assign ov_fifo_din  = din_r;
    assign o_complete   = complete_r;
    assign o_overflow   = overflow_r;
    assign ov_word_cnt  = word_cnt_r;

endmodule

// File: tb/tb_ddr_wr_packer.sv
// ----------------------------------------------------------------------------
// tb_ddr_wr_packer
// Self-checking bench for ddr_wr_packer. Expected FIFO words are pushed to a
// queue when their samples are driven and popped whenever the DUT strobes
// o_fifo_wr_en. A cycle table covers a padded flush, settle timing and the
// ignored-input cases; hand sequences cover the remaining corner cases.
// ----------------------------------------------------------------------------
module tb_ddr_wr_packer;
    import ddr_wr_packer_pkg::*;

    localparam int DW = DDR_DATA_W;
    localparam int PN = DDR_PACK_NUM;
    localparam int SC = DDR_SETTLE_CYC;
    localparam int WW = DW * PN;

    logic            ddr_ui_clk = 1'b0;
    logic            ddr_log_rst_n;
    logic            i_acq_start;
    logic            i_acq_stop;
    logic            i_data_vld;
    logic [DW-1:0]   iv_data;
    logic            i_fifo_full;
    logic            o_fifo_wr_en;
    logic [WW-1:0]   ov_fifo_din;
    logic            o_complete;
    logic            o_overflow;
    logic [31:0]     ov_word_cnt;

    int              n_cmp = 0;
    int              n_bad = 0;
    int              cyc = 0;
    int              last_wr_cyc = -1;
    logic [WW-1:0]   exp_q[$];

    typedef struct {
        logic        start;
        logic        stop;
        logic        vld;
        logic [31:0] data;
        logic        full;
        logic        exp_wr;
        logic        exp_cmp;
        logic        exp_ovf;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t tbl[20];

    ddr_wr_packer #(
        .DATA_WIDTH (DW),
        .PACK_NUM   (PN),
        .SETTLE_CYC (SC)
    ) dut (
        .ddr_ui_clk    (ddr_ui_clk),
        .ddr_log_rst_n (ddr_log_rst_n),
        .i_acq_start   (i_acq_start),
        .i_acq_stop    (i_acq_stop),
        .i_data_vld    (i_data_vld),
        .iv_data       (iv_data),
        .i_fifo_full   (i_fifo_full),
        .o_fifo_wr_en  (o_fifo_wr_en),
        .ov_fifo_din   (ov_fifo_din),
        .o_complete    (o_complete),
        .o_overflow    (o_overflow),
        .ov_word_cnt   (ov_word_cnt)
    );

    // Free-running UI clock
    always #5 ddr_ui_clk = ~ddr_ui_clk;

    function automatic vec_t mkv(input logic st, input logic sp, input logic v,
                                 input logic [31:0] d, input logic f,
                                 input logic ew, input logic ec, input logic eo,
                                 input logic [31:0] en);
        vec_t r;
        r.start = st; r.stop = sp; r.vld = v; r.data = d; r.full = f;
        r.exp_wr = ew; r.exp_cmp = ec; r.exp_ovf = eo; r.exp_cnt = en;
        return r;
    endfunction

    function automatic logic [WW-1:0] mk_word(input logic [31:0] first, input int n);
        logic [WW-1:0] w;
        w = '0;
        for (int k = 0; k < n; k++) begin
            w[k*DW +: DW] = first + 32'(k);
        end
        return w;
    endfunction

    task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic sp, input logic v,
                         input logic [31:0] d, input logic f);
        i_acq_start = st;
        i_acq_stop  = sp;
        i_data_vld  = v;
        iv_data     = d;
        i_fifo_full = f;
    endtask

    // Advance one clock, then score any FIFO write the DUT just produced
    task automatic step();
        logic [WW-1:0] e;
        @(posedge ddr_ui_clk);
        #1;
        cyc++;
        if (o_fifo_wr_en === 1'b1) begin
            last_wr_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", WW'(o_fifo_wr_en), WW'(0));
            end else begin
                e = exp_q.pop_front();
                chk("fifo_word", ov_fifo_din, e);
            end
        end
    endtask

    task automatic send(input logic [31:0] first, input int n);
        for (int k = 0; k < n; k++) begin
            drive(1'b0, 1'b0, 1'b1, first + 32'(k), 1'b0);
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic wait_complete(input string name, input int bound);
        int k;
        k = 0;
        while ((o_complete !== 1'b1) && (k < bound)) begin
            step();
            k++;
        end
        chk(name, WW'(o_complete), WW'(1));
    endtask

    initial begin
        int w;

        // padded flush of 0xA,0xB,0xC, settle timing, ignored inputs
        tbl[0]  = mkv(1'b1, 1'b0, 1'b0, 32'h0,    1'b0,  1'b0, 1'b0, 1'b0, 32'd0);
        tbl[1]  = mkv(1'b0, 1'b0, 1'b1, 32'hA,    1'b0,  1'b0, 1'b0, 1'b0, 32'd0);
        tbl[2]  = mkv(1'b0, 1'b0, 1'b1, 32'hB,    1'b0,  1'b0, 1'b0, 1'b0, 32'd0);
        tbl[3]  = mkv(1'b0, 1'b0, 1'b1, 32'hC,    1'b0,  1'b0, 1'b0, 1'b0, 32'd0);
        tbl[4]  = mkv(1'b0, 1'b1, 1'b0, 32'h0,    1'b0,  1'b0, 1'b0, 1'b0, 32'd0);
        tbl[5]  = mkv(1'b0, 1'b0, 1'b0, 32'h0,    1'b0,  1'b1, 1'b0, 1'b0, 32'd1);
        tbl[6]  = mkv(1'b0, 1'b0, 1'b0, 32'h0,    1'b0,  1'b0, 1'b0, 1'b0, 32'd1);
        tbl[7]  = mkv(1'b0, 1'b0, 1'b0, 32'h0,    1'b0,  1'b0, 1'b0, 1'b0, 32'd1);
        tbl[8]  = mkv(1'b0, 1'b0, 1'b0, 32'h0,    1'b0,  1'b0, 1'b0, 1'b0, 32'd1);
        tbl[9]  = mkv(1'b0, 1'b0, 1'b0, 32'h0,    1'b0,  1'b0, 1'b0, 1'b0, 32'd1);
        tbl[10] = mkv(1'b0, 1'b0, 1'b0, 32'h0,    1'b0,  1'b0, 1'b1, 1'b0, 32'd1);
        tbl[11] = mkv(1'b0, 1'b0, 1'b0, 32'h0,    1'b0,  1'b0, 1'b1, 1'b0, 32'd1);
        tbl[12] = mkv(1'b0, 1'b1, 1'b1, 32'hDEAD, 1'b0,  1'b0, 1'b1, 1'b0, 32'd1);
        tbl[13] = mkv(1'b1, 1'b0, 1'b0, 32'h0,    1'b0,  1'b0, 1'b0, 1'b0, 32'd0);
        tbl[14] = mkv(1'b0, 1'b1, 1'b0, 32'h0,    1'b0,  1'b0, 1'b0, 1'b0, 32'd0);
        tbl[15] = mkv(1'b0, 1'b0, 1'b0, 32'h0,    1'b0,  1'b0, 1'b0, 1'b0, 32'd0);
        tbl[16] = mkv(1'b1, 1'b0, 1'b1, 32'h55,   1'b0,  1'b0, 1'b0, 1'b0, 32'd0);
        tbl[17] = mkv(1'b0, 1'b0, 1'b0, 32'h0,    1'b0,  1'b0, 1'b0, 1'b0, 32'd0);
        tbl[18] = mkv(1'b0, 1'b0, 1'b0, 32'h0,    1'b0,  1'b0, 1'b0, 1'b0, 32'd0);
        tbl[19] = mkv(1'b0, 1'b0, 1'b0, 32'h0,    1'b0,  1'b0, 1'b1, 1'b0, 32'd0);

        // reset state
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        ddr_log_rst_n = 1'b0;
        step();
        step();
        ddr_log_rst_n = 1'b1;
        chk("rst_wr_en",    WW'(o_fifo_wr_en), WW'(0));
        chk("rst_din",      ov_fifo_din,       WW'(0));
        chk("rst_complete", WW'(o_complete),   WW'(0));
        chk("rst_overflow", WW'(o_overflow),   WW'(0));
        chk("rst_word_cnt", WW'(ov_word_cnt),  WW'(0));

        // table: one row per cycle, outputs checked after the row's edge
        exp_q.push_back(mk_word(32'hA, 3));
        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].start, tbl[i].stop, tbl[i].vld, tbl[i].data, tbl[i].full);
            step();
            chk($sformatf("tbl%0d_wr_en", i),    WW'(o_fifo_wr_en), WW'(tbl[i].exp_wr));
            chk($sformatf("tbl%0d_complete", i), WW'(o_complete),   WW'(tbl[i].exp_cmp));
            chk($sformatf("tbl%0d_overflow", i), WW'(o_overflow),   WW'(tbl[i].exp_ovf));
            chk($sformatf("tbl%0d_word_cnt", i), WW'(ov_word_cnt),  WW'(tbl[i].exp_cnt));
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

        // 16 samples 0x1..0x10 -> two full words
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        exp_q.push_back(mk_word(32'h1, 8));
        exp_q.push_back(mk_word(32'h9, 8));
        send(32'h1, 16);
        step();
        chk("two_words_cnt",   WW'(ov_word_cnt),  WW'(2));
        chk("two_words_drain", WW'(exp_q.size()), WW'(0));
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        wait_complete("two_words_complete", 20);

        // full on the 8th sample -> word dropped, sticky overflow
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        send(32'h40, 7);
        drive(1'b0, 1'b0, 1'b1, 32'h47, 1'b1);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        step();
        chk("drop_overflow", WW'(o_overflow),  WW'(1));
        chk("drop_cnt",      WW'(ov_word_cnt), WW'(0));
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 3; k++) step();
        chk("drop_sticky", WW'(o_overflow), WW'(1));
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        wait_complete("drop_complete", 20);
        chk("drop_sticky_done", WW'(o_overflow), WW'(1));

        // stop coincident with the 8th sample -> write in first FLUSH cycle
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        chk("start_clears_ovf", WW'(o_overflow), WW'(0));
        chk("start_clears_cmp", WW'(o_complete), WW'(0));
        exp_q.push_back(mk_word(32'h100, 8));
        send(32'h100, 7);
        drive(1'b0, 1'b1, 1'b1, 32'h107, 1'b0);
        step();
        chk("stop8_wr_en", WW'(o_fifo_wr_en), WW'(1));
        w = cyc;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        wait_complete("stop8_complete", 20);
        chk("stop8_latency", WW'(cyc - w), WW'(SC + 1));
        chk("stop8_cnt",     WW'(ov_word_cnt), WW'(1));

        // reset mid-RUN discards the partial word
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        send(32'h200, 5);
        ddr_log_rst_n = 1'b0;
        step();
        ddr_log_rst_n = 1'b1;
        chk("mrst_wr_en",    WW'(o_fifo_wr_en), WW'(0));
        chk("mrst_din",      ov_fifo_din,       WW'(0));
        chk("mrst_complete", WW'(o_complete),   WW'(0));
        chk("mrst_overflow", WW'(o_overflow),   WW'(0));
        chk("mrst_word_cnt", WW'(ov_word_cnt),  WW'(0));
        for (int k = 0; k < 3; k++) step();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        exp_q.push_back(mk_word(32'h20, 8));
        exp_q.push_back(mk_word(32'h28, 8));
        send(32'h20, 16);
        step();
        chk("mrst_again_cnt",   WW'(ov_word_cnt),  WW'(2));
        chk("mrst_again_drain", WW'(exp_q.size()), WW'(0));
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        wait_complete("mrst_again_complete", 20);

        // stop at lane 2 while FIFO full -> padded word once full drops
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        send(32'h300, 2);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 10; k++) step();
        chk("full_wait_cnt", WW'(ov_word_cnt), WW'(0));
        exp_q.push_back(mk_word(32'h300, 2));
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        chk("full_release_wr_en", WW'(o_fifo_wr_en), WW'(1));
        chk("full_release_ovf",   WW'(o_overflow),   WW'(0));
        wait_complete("full_release_complete", 20);
        chk("full_release_cnt", WW'(ov_word_cnt), WW'(1));
        chk("full_release_ovf2", WW'(o_overflow), WW'(0));

        chk("final_drain", WW'(exp_q.size()), WW'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ddr_wr_packer.md
DDR_WR_PACKER -- requirements
Module: ddr_wr_packer

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 32, sample width; PACK_NUM, 8, samples per 256-bit word; SETTLE_CYC, 4, cycles between the last FIFO write and o_complete rising.
REQ-002 ddr_ui_clk  in  1  sole clock; all logic on rising edge.
REQ-003 ddr_log_rst_n  in  1  synchronous reset, active-low.
REQ-004 i_acq_start  in  1  single-cycle pulse; begin acquisition.
REQ-005 i_acq_stop  in  1  single-cycle pulse; end acquisition and flush.
REQ-006 i_data_vld  in  1  sample valid qualifier.
REQ-007 iv_data  in  32  sample.
REQ-008 i_fifo_full  in  1  write-side full of the 256-bit FIFO feeding the DDR write/read FSM.
REQ-009 o_fifo_wr_en  out  1  FIFO write strobe, one word per cycle.
REQ-010 ov_fifo_din  out  256  packed word, valid with o_fifo_wr_en.
REQ-011 o_complete  out  1  level; drives the DDR FSM complete input.
REQ-012 o_overflow  out  1  sticky; a packed word was dropped.
REQ-013 ov_word_cnt  out  32  FIFO words written since the last start.

Function
REQ-014 The FSM SHALL have the states IDLE, RUN, FLUSH, SETTLE and DONE, encoded as a 3-bit register.
REQ-015 IDLE/DONE: i_acq_start -> RUN; clear lane counter, shift register, ov_word_cnt, o_overflow and o_complete in the same cycle.
REQ-016 RUN: each cycle with i_data_vld=1 SHALL place iv_data in lane[lane_cnt]; lane k occupies bits [32k+31:32k], so the first sample is in [31:0].
REQ-017 lane_cnt SHALL count 0..PACK_NUM-1 and wrap to 0 on the accepting cycle at lane PACK_NUM-1.
REQ-018 Completing lane 7 SHALL assert o_fifo_wr_en with the full word exactly 1 cycle later (registered output).
REQ-019 If i_fifo_full=1 in the cycle the write would issue, the write SHALL be suppressed, the word dropped, o_overflow set, and ov_word_cnt left unchanged.
REQ-020 RUN + i_acq_stop -> FLUSH; a sample valid in the stop cycle SHALL be accepted first.
REQ-021 FLUSH, lane_cnt != 0 (after the REQ-020 sample): when i_fifo_full=0, write one word with unfilled lanes zero, then -> SETTLE; while full, wait with no drop.
REQ-022 FLUSH, lane_cnt = 0: write nothing and go directly to SETTLE.
REQ-023 A pending full-word write from the final RUN cycle SHALL issue in the first FLUSH cycle, before any padded word, subject to REQ-019.
REQ-024 SETTLE SHALL count SETTLE_CYC cycles, then -> DONE; o_complete SHALL rise on DONE entry and stay high until the next i_acq_start.
REQ-025 i_data_vld SHALL be ignored outside RUN, i_acq_stop outside RUN, and i_acq_start in RUN/FLUSH/SETTLE.
REQ-026 ov_word_cnt SHALL increment by 1 per o_fifo_wr_en and wrap modulo 2^32.
REQ-027 At most one FIFO write SHALL issue per cycle; o_fifo_wr_en SHALL never assert in IDLE, SETTLE or DONE.

Reset
REQ-028 ddr_log_rst_n=0 at a clock edge SHALL force IDLE, lane_cnt=0, shift register=0, o_fifo_wr_en=0, ov_fifo_din=0, o_complete=0, o_overflow=0, ov_word_cnt=0.
REQ-029 Reset mid-RUN/FLUSH SHALL discard the partial word and issue no further write; the first cycle after reset release is IDLE.

Structure
REQ-030 A shared package SHALL hold the state encoding, PACK_NUM, SETTLE_CYC and the 256-bit word width, used by both this block and the DDR FSM.
REQ-031 This block SHALL be a single module with no sub-modules; the FIFO sits outside it.

Verification
REQ-032 Start, 16 consecutive valid samples 0x1..0x10, fifo not full -> two writes; word0[31:0]=0x1, word0[255:224]=0x8, word1[255:224]=0x10; ov_word_cnt=2.
REQ-033 Start, 3 samples 0xA,0xB,0xC, then stop -> one write {0..0,0xC,0xB,0xA} with lanes 3-7 zero; o_complete high exactly SETTLE_CYC+1 cycles after that write.
REQ-034 Start, 8 samples, i_fifo_full=1 on the write cycle -> no write, o_overflow=1, ov_word_cnt=0; o_overflow stays 1 until the next start.
REQ-035 Stop coincident with the 8th sample -> full word written in the first FLUSH cycle, no padded word; complete follows per REQ-024.
REQ-036 Start, 5 samples, ddr_log_rst_n low for 1 cycle -> no write, all outputs 0, state IDLE; a new start then behaves as REQ-032.
REQ-037 Stop with lane_cnt=2 while i_fifo_full=1 for 10 cycles -> padded word written on the first cycle after full deasserts; nothing dropped; o_overflow=0.
